hwag_sync_gen: RTL

- Parametrised crank-wheel synchroniser, successor of the fixed 60-2 HWAG front end.
- Measures tooth periods from the crank sensor input and finds the missing-tooth gap with a configurable ratio test.
- Tracks tooth number, verifies the gap every revolution and reports sync loss and stall.
- Feeds the angle generator and tooth/revolution consumers.

---
 rtl/hwag_sync_gen.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/hwag_sync_gen.sv
// Crank-wheel synchroniser: measures tooth periods, locates the missing-tooth gap
// with a shift-based ratio test, tracks tooth numbering and flags sync loss / stall.
module hwag_sync_gen #(
    parameter int PCNT_WIDTH    = 24,
    parameter int TCNT_WIDTH    = 6,
    parameter int TEETH_TOTAL   = 60,
    parameter int TEETH_MISSING = 2,
    parameter int TCNT_LOAD     = 2,
    parameter int GAP_SHIFT     = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,          // synchronous, active-low
    input  logic                  i_cap,
    input  logic                  i_cap_edge_sel,
    input  logic                  i_err_clr,
    output logic                  o_sync,
    output logic [TCNT_WIDTH-1:0] o_tcnt,
    output logic [PCNT_WIDTH-1:0] o_period,
    output logic                  o_tooth_stb,
    output logic                  o_rev_stb,
    output logic                  o_gap_err,
    output logic                  o_stall,
    output logic                  o_err_sticky,
    output logic [1:0]            o_state
);

    localparam int TCNT_TOP = TEETH_TOTAL - TEETH_MISSING - 1;
    localparam logic [TCNT_WIDTH-1:0] TCNT_TOP_V  = TCNT_WIDTH'(TCNT_TOP);
    localparam logic [TCNT_WIDTH-1:0] TCNT_LOAD_V = TCNT_WIDTH'(TCNT_LOAD);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ARM    = 2'd1,
        S_SEARCH = 2'd2,
        S_SYNC   = 2'd3
    } state_t;

    function automatic logic is_short(input logic [PCNT_WIDTH-1:0] x,
                                      input logic [PCNT_WIDTH-1:0] y);
        return x < (y >> GAP_SHIFT);
    endfunction

    state_t                  r_state;
    logic                    r_cap_p0, r_cap_p1;
    logic [PCNT_WIDTH-1:0]   r_pcnt;
    logic [PCNT_WIDTH-1:0]   r_p1, r_p2, r_p3;
    logic [TCNT_WIDTH-1:0]   r_tcnt;
    logic [1:0]              r_arm_cnt;
    logic                    r_sync;
    logic                    r_tooth_stb, r_rev_stb, r_gap_err, r_stall, r_err_sticky;

    logic w_edge, w_gap_found, w_gap_now, w_last, w_shift;

    assign w_edge      = i_cap_edge_sel ? (~r_cap_p0 & r_cap_p1) : (r_cap_p0 & ~r_cap_p1);
    assign w_gap_found = is_short(r_p1, r_p2) & is_short(r_p3, r_p2);
    assign w_gap_now   = is_short(r_p1, r_pcnt);
    assign w_last      = (r_tcnt == TCNT_TOP_V);
    // A confirmed gap period is kept out of the history so p1..p3 stay normal teeth
    assign w_shift     = w_edge & ((r_state == S_ARM) | (r_state == S_SEARCH) |
                                   ((r_state == S_SYNC) & ~(w_last & w_gap_now)));

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state      <= S_IDLE;
            r_cap_p0     <= 1'b0;
            r_cap_p1     <= 1'b0;
            r_pcnt       <= '0;
            r_p1         <= '0;
            r_p2         <= '0;
            r_p3         <= '0;
            r_tcnt       <= '0;
            r_arm_cnt    <= '0;
            r_sync       <= 1'b0;
            r_tooth_stb  <= 1'b0;
            r_rev_stb    <= 1'b0;
            r_gap_err    <= 1'b0;
            r_stall      <= 1'b0;
            r_err_sticky <= 1'b0;
        end else begin
            r_cap_p0    <= i_cap;
            r_cap_p1    <= r_cap_p0;
            r_tooth_stb <= 1'b0;
            r_rev_stb   <= 1'b0;
            r_gap_err   <= 1'b0;
            r_stall     <= 1'b0;
            if (i_err_clr)
                r_err_sticky <= 1'b0;

            if (w_edge) begin
                r_pcnt <= PCNT_WIDTH'(1);
                if (w_shift) begin
                    r_p3 <= r_p2;
                    r_p2 <= r_p1;
                    r_p1 <= r_pcnt;
                end
                case (r_state)
                    S_IDLE: begin
                        r_state   <= S_ARM;
                        r_arm_cnt <= '0;
                    end
                    S_ARM: begin
                        r_arm_cnt <= r_arm_cnt + 2'd1;
                        if (r_arm_cnt == 2'd2)
                            r_state <= S_SEARCH;
                    end
                    S_SEARCH: begin
                        if (w_gap_found) begin
                            r_state     <= S_SYNC;
                            r_tcnt      <= TCNT_LOAD_V;
                            r_sync      <= 1'b1;
                            r_tooth_stb <= 1'b1;
                        end
                    end
                    S_SYNC: begin
                        if (w_last && w_gap_now) begin
                            r_tcnt      <= '0;
                            r_tooth_stb <= 1'b1;
                            r_rev_stb   <= 1'b1;
                        end else if (!w_last && !w_gap_now) begin
                            r_tcnt      <= r_tcnt + TCNT_WIDTH'(1);
                            r_tooth_stb <= 1'b1;
                        end else begin
                            // premature gap or missing gap: drop numbering and hunt again
                            r_gap_err    <= 1'b1;
                            r_err_sticky <= 1'b1;
                            r_state      <= S_SEARCH;
                            r_tcnt       <= '0;
                            r_sync       <= 1'b0;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end else if (r_state != S_IDLE) begin
                if (&r_pcnt) begin
                    r_stall      <= 1'b1;
                    r_err_sticky <= 1'b1;
                    r_state      <= S_IDLE;
                    r_pcnt       <= '0;
                    r_p1         <= '0;
                    r_p2         <= '0;
                    r_p3         <= '0;
                    r_tcnt       <= '0;
                    r_arm_cnt    <= '0;
                    r_sync       <= 1'b0;
                end else begin
                    r_pcnt <= r_pcnt + PCNT_WIDTH'(1);
                end
            end
        end
    end

    assign o_sync       = r_sync;
    assign o_tcnt       = r_tcnt;
    assign o_period     = r_p1;
    assign o_tooth_stb  = r_tooth_stb;
    assign o_rev_stb    = r_rev_stb;
    assign o_gap_err    = r_gap_err;
    assign o_stall      = r_stall;
    assign o_err_sticky = r_err_sticky;
    assign o_state      = r_state;

endmodule
